// File: rtl/nrisc_mem_responder.sv
// Shared single-port RAM responder for the nRISC fetch and data ports.
// A three-state arbiter serialises accesses, each taking WAIT_CYCLES wait states plus a one-cycle ack.
module nrisc_mem_responder #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1,
    parameter int STARVE_MAX  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_data,
    output logic              if_ack,
    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              busy,
    output logic              err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SC_W  = $clog2(STARVE_MAX + 2);
    localparam logic [3:0]      WAIT_INIT  = 4'(WAIT_CYCLES);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [3:0]          wait_cnt_r;
    logic [SC_W-1:0]     starve_r;
    logic                port_dm_r;
    logic                op_wr_r;
    logic [IDX_W-1:0]    addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [DATA_W-1:0]   if_data_r;
    logic [DATA_W-1:0]   dm_rdata_r;
    logic                if_ack_r;
    logic                dm_ack_r;
    logic                busy_r;
    logic                err_r;
    logic [DATA_W-1:0]   ram_r [DEPTH];

    logic                grant_s;
    logic                grant_dm_s;
    logic                commit_s;
    logic                acc_dm_s;
    logic                acc_wr_s;
    logic [IDX_W-1:0]    acc_addr_s;
    logic [DATA_W-1:0]   acc_wdata_s;

    // Arbitration, next state, and the access performed on the edge entering DONE.
    // With zero wait states the grant and the RAM access share one edge, so IDLE forwards the live inputs.
    always_comb begin
        state_s     = state_r;
        grant_s     = 1'b0;
        grant_dm_s  = 1'b0;
        commit_s    = 1'b0;
        acc_dm_s    = port_dm_r;
        acc_wr_s    = op_wr_r;
        acc_addr_s  = addr_r;
        acc_wdata_s = wdata_r;
        case (state_r)
            S_IDLE: begin
                if ((dm_rd || dm_wr) && !(if_req && (starve_r == STARVE_LIM))) begin
                    grant_s    = 1'b1;
                    grant_dm_s = 1'b1;
                end else if (if_req) begin
                    grant_s    = 1'b1;
                    grant_dm_s = 1'b0;
                end else begin
                    grant_s    = 1'b0;
                    grant_dm_s = 1'b0;
                end
                if (grant_s) begin
                    acc_dm_s    = grant_dm_s;
                    acc_wr_s    = grant_dm_s & dm_wr;
                    acc_addr_s  = grant_dm_s ? dm_addr[IDX_W-1:0] : if_addr[IDX_W-1:0];
                    acc_wdata_s = dm_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_s  = S_DONE;
                        commit_s = 1'b1;
                    end else begin
                        state_s  = S_WAIT;
                        commit_s = 1'b0;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (wait_cnt_r <= 4'd1) begin
                    state_s  = S_DONE;
                    commit_s = 1'b1;
                end else begin
                    state_s  = S_WAIT;
                end
            end
            S_DONE: state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State, access latches, starvation tracking and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            wait_cnt_r <= 4'd0;
            starve_r   <= '0;
            port_dm_r  <= 1'b0;
            op_wr_r    <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= '0;
            if_data_r  <= '0;
            dm_rdata_r <= '0;
            if_ack_r   <= 1'b0;
            dm_ack_r   <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r  <= state_s;
            busy_r   <= (state_s != S_IDLE);
            if_ack_r <= commit_s & ~acc_dm_s;
            dm_ack_r <= commit_s & acc_dm_s;
            if (dm_rd && dm_wr) begin
                err_r <= 1'b1;
            end
            if (grant_s) begin
                port_dm_r  <= acc_dm_s;
                op_wr_r    <= acc_wr_s;
                addr_r     <= acc_addr_s;
                wdata_r    <= acc_wdata_s;
                wait_cnt_r <= WAIT_INIT;
                // A data grant only counts against the fetch port when a fetch is actually waiting.
                if (grant_dm_s && if_req) begin
                    starve_r <= (starve_r == STARVE_LIM) ? starve_r : starve_r + 1'b1;
                end else begin
                    starve_r <= '0;
                end
            end else if (state_r == S_WAIT) begin
                wait_cnt_r <= wait_cnt_r - 4'd1;
            end
            if (commit_s && !acc_wr_s) begin
                if (acc_dm_s) begin
                    dm_rdata_r <= ram_r[acc_addr_s];
                end else begin
                    if_data_r <= ram_r[acc_addr_s];
                end
            end
        end
    end

    // RAM write port; a reset on the commit edge drops the write.
    always_ff @(posedge clk) begin
        if (!reset && commit_s && acc_wr_s) begin
            ram_r[acc_addr_s] <= acc_wdata_s;
        end
    end

    assign if_data  = if_data_r;
    assign if_ack   = if_ack_r;
    assign dm_rdata = dm_rdata_r;
    assign dm_ack   = dm_ack_r;
    assign busy     = busy_r;
    assign err      = err_r;

endmodule
